// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// aluop classes and the ALU operation codes understood by the datapath ALU.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10
    } statetype;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // aluop classes handed from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the FSM's aluop class plus the instruction
// funct fields onto the 3-bit ALU operation code.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    // Decode operation; only R-type with funct7b5 set turns funct3=000 into sub
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alucontrol = ALU_SLL;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b011:  alucontrol = ALU_ADD;
                    3'b100:  alucontrol = ALU_XOR;
                    3'b101:  alucontrol = ALU_SRL;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: Moore main FSM sequencing fetch/decode/execute/
// writeback, immediate-format decode, branch resolution and ALU decode.
// Build option: define MC_CTRL_BNE_EN to let funct3[0] invert the branch
// condition in the BEQ state (bne support); otherwise branches test zero only.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic       regwrite,
    output logic [1:0] immsrc,
    output logic [2:0] alucontrol
);

    statetype   state_q, state_d;
    logic [1:0] aluop;
    logic       branch;
    logic       pcupdate;
    logic       take;

    // State register; reset aborts any in-flight instruction back to fetch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unrecognised opcodes fall straight back to fetch
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_R:         state_d = StExecuteR;
                    OP_I:         state_d = StExecuteI;
                    OP_BEQ:       state_d = StBeq;
                    OP_JAL:       state_d = StJal;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
            StMemRead:  state_d = StMemWb;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StJal:      state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    // Moore control outputs decoded from the current state
    always_comb begin
        adrsrc    = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        resultsrc = 2'b00;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        regwrite  = 1'b0;
        aluop     = ALUOP_ADD;
        branch    = 1'b0;
        pcupdate  = 1'b0;
        case (state_q)
            StFetch: begin
                irwrite   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                pcupdate  = 1'b1;
            end
            StDecode: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            StMemAdr: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            StMemRead: adrsrc = 1'b1;
            StMemWb: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
            end
            StMemWrite: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            StExecuteR: begin
                alusrca = 2'b10;
                aluop   = ALUOP_FUNCT;
            end
            StExecuteI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = ALUOP_FUNCT;
            end
            StAluWb: regwrite = 1'b1;
            StBeq: begin
                alusrca = 2'b10;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            StJal: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
            end
            default: ;
        endcase
    end

    // Branch condition and PC enable (the only output that sees zero)
    always_comb begin
`ifdef MC_CTRL_BNE_EN
        take = funct3[0] ? ~zero : zero;
`else
        take = zero;
`endif
        pcwrite = pcupdate | (branch & take);
    end

    // Immediate format straight from the opcode
    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (alucontrol)
    );

endmodule
